// File: rtl/ysyx_22040127_writeback_pkg.sv
// Shared WB-stage definitions: MEM->WB bus layout, machine CSR map and mstatus fields.
package ysyx_22040127_writeback_pkg;

  localparam int unsigned MEM_TO_WB_WIDTH = 321;

  // Field bit offsets within the MEM->WB bus
  localparam int unsigned MEMWRITE_BIT   = 320;
  localparam int unsigned DIFF_DATA_LSB  = 256;
  localparam int unsigned DIFF_ADDR_LSB  = 192;
  localparam int unsigned DES_CSR_LSB    = 180;
  localparam int unsigned ALU_INPUT1_LSB = 116;
  localparam int unsigned RS1_LSB        = 111;
  localparam int unsigned CSR_WE_BIT     = 110;
  localparam int unsigned MRET_BIT       = 109;
  localparam int unsigned ECALL_BIT      = 108;
  localparam int unsigned CSR_OP_LSB     = 102;
  localparam int unsigned PC_LSB         = 70;
  localparam int unsigned REG_WEN_BIT    = 69;
  localparam int unsigned RD_LSB         = 64;
  localparam int unsigned REG_WDATA_LSB  = 0;

  typedef struct packed {
    logic        memwrite;
    logic [63:0] diff_data;
    logic [63:0] diff_addr;
    logic [11:0] des_csr;
    logic [63:0] alu_input1;
    logic [4:0]  rs1;
    logic        csr_we;
    logic        mret;
    logic        ecall;
    logic [5:0]  csr_op;     // {csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci}
    logic [31:0] pc;
    logic        reg_wen;
    logic [4:0]  rd;
    logic [63:0] reg_wdata;
  } mem_to_wb_t;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int unsigned MSTATUS_MIE     = 3;
  localparam int unsigned MSTATUS_MPIE    = 7;
  localparam int unsigned MSTATUS_MPP_LSB = 11;
  localparam int unsigned MSTATUS_MPP_MSB = 12;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

  typedef enum logic [1:0] {CsrNone, CsrWrite, CsrSet, CsrClear} csr_op_e;

  function automatic csr_op_e csr_op_decode(input logic [5:0] op);
    csr_op_e kind;
    unique case (1'b1)
      op[5], op[2]: kind = CsrWrite;
      op[4], op[1]: kind = CsrSet;
      op[3], op[0]: kind = CsrClear;
      default:      kind = CsrNone;
    endcase
    return kind;
  endfunction

  function automatic logic csr_op_is_imm(input logic [5:0] op);
    return |op[2:0];
  endfunction

endpackage

// File: rtl/ysyx_22040127_csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mepc/mcause, ecall/mret side effects and instret.
// Optional mcycle/minstret CSRs are built when WB_COUNTERS_EN is defined.
module ysyx_22040127_csr_file
  import ysyx_22040127_writeback_pkg::*;
#(
  parameter logic [63:0] MSTATUS_RST = 64'h0000_000a_0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [11:0] i_addr,
  input  csr_op_e     i_op,
  input  logic [63:0] i_src,
  input  logic        i_csr_we,
  input  logic        i_ecall,
  input  logic        i_mret,
  input  logic [31:0] i_pc,
  output logic [63:0] o_rdata,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc,
  output logic [63:0] o_instret
);

  logic [63:0] r_mstatus;
  logic [63:0] r_mtvec;
  logic [63:0] r_mepc;
  logic [63:0] r_mcause;
  logic [63:0] r_instret;
`ifdef WB_COUNTERS_EN
  logic [63:0] r_mcycle;
`endif

  logic [63:0] w_wdata;
  logic        w_do_write;
  logic        w_csr_wr;
  logic        w_ecall;
  logic        w_mret;

  assign w_ecall = i_valid && i_ecall;
  assign w_mret  = i_valid && i_mret && !i_ecall;

  always_comb begin
    o_rdata = '0;
    case (i_addr)
      CSR_MSTATUS:  o_rdata = r_mstatus;
      CSR_MTVEC:    o_rdata = r_mtvec;
      CSR_MEPC:     o_rdata = r_mepc;
      CSR_MCAUSE:   o_rdata = r_mcause;
`ifdef WB_COUNTERS_EN
      CSR_MCYCLE:   o_rdata = r_mcycle;
      CSR_MINSTRET: o_rdata = r_instret;
`endif
      default:      o_rdata = '0;
    endcase
  end

  // Set/clear with a zero operand is a pure read and must not disturb the CSR
  always_comb begin
    w_wdata    = o_rdata;
    w_do_write = 1'b0;
    case (i_op)
      CsrWrite: begin
        w_wdata    = i_src;
        w_do_write = 1'b1;
      end
      CsrSet: begin
        w_wdata    = o_rdata | i_src;
        w_do_write = |i_src;
      end
      CsrClear: begin
        w_wdata    = o_rdata & ~i_src;
        w_do_write = |i_src;
      end
      default: begin
        w_wdata    = o_rdata;
        w_do_write = 1'b0;
      end
    endcase
  end

  assign w_csr_wr = i_valid && i_csr_we && !i_ecall && !i_mret && w_do_write;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mstatus <= MSTATUS_RST;
      r_mtvec   <= '0;
      r_mepc    <= '0;
      r_mcause  <= '0;
    end else if (w_ecall) begin
      r_mepc                                     <= {32'b0, i_pc};
      r_mcause                                   <= CAUSE_ECALL_M;
      r_mstatus[MSTATUS_MPIE]                    <= r_mstatus[MSTATUS_MIE];
      r_mstatus[MSTATUS_MIE]                     <= 1'b0;
      r_mstatus[MSTATUS_MPP_MSB:MSTATUS_MPP_LSB] <= 2'b11;
    end else if (w_mret) begin
      r_mstatus[MSTATUS_MIE]  <= r_mstatus[MSTATUS_MPIE];
      r_mstatus[MSTATUS_MPIE] <= 1'b1;
    end else if (w_csr_wr) begin
      case (i_addr)
        CSR_MSTATUS: r_mstatus <= w_wdata;
        CSR_MTVEC:   r_mtvec   <= w_wdata;
        CSR_MEPC:    r_mepc    <= w_wdata;
        CSR_MCAUSE:  r_mcause  <= w_wdata;
        default:     ;
      endcase
    end
  end

`ifdef WB_COUNTERS_EN
  // An explicit CSR write wins over that cycle's automatic increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle <= '0;
    end else if (w_csr_wr && i_addr == CSR_MCYCLE) begin
      r_mcycle <= w_wdata;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (w_csr_wr && i_addr == CSR_MINSTRET) begin
      r_instret <= w_wdata;
    end else if (i_valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (i_valid) begin
      r_instret <= r_instret + 64'd1;
    end
  end
`endif

  assign o_mtvec   = r_mtvec[31:0];
  assign o_mepc    = r_mepc[31:0];
  assign o_instret = r_instret;

  logic w_unused_upper;
  assign w_unused_upper = ^{r_mtvec[63:32], r_mepc[63:32]};

endmodule

// File: rtl/ysyx_22040127_writeback.sv
// WB pipeline stage: latches the MEM->WB bus, drives the register-file write port, commits,
// and turns ecall/mret into a flush + redirect. WB_COUNTERS_EN adds mcycle/minstret CSRs.
module ysyx_22040127_writeback
  import ysyx_22040127_writeback_pkg::*;
#(
  parameter int unsigned MEM_TO_WB_WIDTH = 321,
  parameter logic [63:0] MSTATUS_RST     = 64'h0000_000a_0000_1800
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_to_wb_valid,
  output logic                       wb_allowin,
  input  logic [MEM_TO_WB_WIDTH-1:0] mem_to_wb_bus,
  output logic                       rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [63:0]                rf_wdata,
  output logic                       wb_flush,
  output logic [31:0]                wb_redirect_pc,
  output logic                       commit_valid,
  output logic [31:0]                commit_pc,
  output logic [63:0]                instret
);

  if (MEM_TO_WB_WIDTH != $bits(mem_to_wb_t)) begin : g_width_check
    $error("MEM_TO_WB_WIDTH does not match the bus layout");
  end

  logic       r_wb_valid;
  mem_to_wb_t r_bus;
  logic       w_ready_go;

  assign w_ready_go = 1'b1;
  assign wb_allowin = !r_wb_valid || w_ready_go;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_bus      <= '0;
    end else if (wb_allowin) begin
      r_wb_valid <= mem_to_wb_valid;
      if (mem_to_wb_valid) begin
        r_bus <= mem_to_wb_t'(mem_to_wb_bus);
      end
    end
  end

  logic        w_is_csr;
  logic [63:0] w_csr_src;
  logic [63:0] w_csr_rdata;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;
  logic        w_ecall_fire;
  logic        w_mret_fire;

  assign w_is_csr  = |r_bus.csr_op;
  assign w_csr_src = csr_op_is_imm(r_bus.csr_op) ? {59'b0, r_bus.rs1} : r_bus.alu_input1;

  ysyx_22040127_csr_file #(
    .MSTATUS_RST (MSTATUS_RST)
  ) u_csr_file (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (r_wb_valid),
    .i_addr    (r_bus.des_csr),
    .i_op      (csr_op_decode(r_bus.csr_op)),
    .i_src     (w_csr_src),
    .i_csr_we  (r_bus.csr_we),
    .i_ecall   (r_bus.ecall),
    .i_mret    (r_bus.mret),
    .i_pc      (r_bus.pc),
    .o_rdata   (w_csr_rdata),
    .o_mtvec   (w_mtvec),
    .o_mepc    (w_mepc),
    .o_instret (instret)
  );

  assign rf_we    = r_wb_valid && r_bus.reg_wen && (r_bus.rd != 5'd0);
  assign rf_waddr = r_bus.rd;
  assign rf_wdata = w_is_csr ? w_csr_rdata : r_bus.reg_wdata;

  assign w_ecall_fire = r_wb_valid && r_bus.ecall;
  assign w_mret_fire  = r_wb_valid && r_bus.mret;
  assign wb_flush     = w_ecall_fire || w_mret_fire;

  always_comb begin
    wb_redirect_pc = '0;
    if (w_ecall_fire) begin
      wb_redirect_pc = {w_mtvec[31:2], 2'b00};
    end else if (w_mret_fire) begin
      wb_redirect_pc = w_mepc;
    end
  end

  assign commit_valid = r_wb_valid;
  assign commit_pc    = r_bus.pc;

  // Difftest/store-tracking fields travel on the bus but are not consumed here
  logic w_unused_bus;
  assign w_unused_bus = ^{r_bus.memwrite, r_bus.diff_data, r_bus.diff_addr};

endmodule
